// File: rtl/id_ex_stage_reg_if.sv
// ID/EX stage bus: decode control, operands and forwarding sources in; EX control and operands out.
// bubble_cnt exists only when IDEX_PERF_CNT_EN is defined.
interface id_ex_stage_reg_if #(
  parameter int DW   = 32,
  parameter int RW   = 5,
  parameter int CNTW = 16
);
  logic          flush;
  logic          id_wreg;
  logic          id_m2reg;
  logic          id_wmem;
  logic [3:0]    id_aluc;
  logic          id_aluimm;
  logic          id_regrt;
  logic [1:0]    id_fwda;
  logic [1:0]    id_fwdb;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic [RW-1:0] id_rd;
  logic [15:0]   id_imm;
  logic [DW-1:0] id_qa;
  logic [DW-1:0] id_qb;
  logic [DW-1:0] ex_alu_res;
  logic [DW-1:0] mem_alu_res;
  logic [DW-1:0] mem_dout;
  logic          mm2reg;
  logic          ewreg;
  logic          em2reg;
  logic          ewmem;
  logic          ealuimm;
  logic [3:0]    ealuc;
  logic [RW-1:0] edestReg;
  logic [DW-1:0] ea;
  logic [DW-1:0] eb;
  logic [DW-1:0] eimm;
  logic          wpcir;
`ifdef IDEX_PERF_CNT_EN
  logic [CNTW-1:0] bubble_cnt;
`endif

  modport master (
    output flush, id_wreg, id_m2reg, id_wmem, id_aluc, id_aluimm, id_regrt,
           id_fwda, id_fwdb, id_rs, id_rt, id_rd, id_imm, id_qa, id_qb,
           ex_alu_res, mem_alu_res, mem_dout, mm2reg,
    input  ewreg, em2reg, ewmem, ealuimm, ealuc, edestReg, ea, eb, eimm, wpcir
`ifdef IDEX_PERF_CNT_EN
    , input bubble_cnt
`endif
  );

  modport slave (
    input  flush, id_wreg, id_m2reg, id_wmem, id_aluc, id_aluimm, id_regrt,
           id_fwda, id_fwdb, id_rs, id_rt, id_rd, id_imm, id_qa, id_qb,
           ex_alu_res, mem_alu_res, mem_dout, mm2reg,
    output ewreg, em2reg, ewmem, ealuimm, ealuc, edestReg, ea, eb, eimm, wpcir
`ifdef IDEX_PERF_CNT_EN
    , output bubble_cnt
`endif
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: operand forwarding, immediate extension, load-use stall and bubble insertion.
// Optional saturating bubble counter enabled by defining IDEX_PERF_CNT_EN.
module id_ex_stage_reg #(
  parameter int DW   = 32,
  parameter int RW   = 5,
  parameter int CNTW = 16
) (
  input logic               clk,
  input logic               rst_n,
  id_ex_stage_reg_if.slave  bus
);

  function automatic logic [DW-1:0] fwd_mux(
    input logic [1:0]    sel,
    input logic [DW-1:0] rf,
    input logic [DW-1:0] ex_res,
    input logic [DW-1:0] mem_res,
    input logic [DW-1:0] mem_load,
    input logic          mem_is_load
  );
    logic [DW-1:0] v;
    case (sel)
      2'b01:   v = ex_res;
      2'b10:   v = mem_is_load ? mem_load : mem_res;
      default: v = rf;
    endcase
    return v;
  endfunction

  logic          r_ewreg;
  logic          r_em2reg;
  logic          r_ewmem;
  logic          r_ealuimm;
  logic [3:0]    r_ealuc;
  logic [RW-1:0] r_edest;
  logic [DW-1:0] r_ea;
  logic [DW-1:0] r_eb;
  logic [DW-1:0] r_eimm;

  logic [DW-1:0] w_fwd_a;
  logic [DW-1:0] w_fwd_b;
  logic [DW-1:0] w_imm_ext;
  logic [RW-1:0] w_dest;
  logic          w_hz;
  logic          w_bubble;

  assign w_fwd_a   = fwd_mux(bus.id_fwda, bus.id_qa, bus.ex_alu_res, bus.mem_alu_res,
                             bus.mem_dout, bus.mm2reg);
  assign w_fwd_b   = fwd_mux(bus.id_fwdb, bus.id_qb, bus.ex_alu_res, bus.mem_alu_res,
                             bus.mem_dout, bus.mm2reg);
  assign w_imm_ext = {{(DW-16){bus.id_imm[15]}}, bus.id_imm};
  assign w_dest    = bus.id_regrt ? bus.id_rt : bus.id_rd;

  // A load in EX whose non-zero destination feeds rs or rt cannot be forwarded in time.
  assign w_hz      = r_ewreg & r_em2reg & (r_edest != RW'(0)) &
                     ((r_edest == bus.id_rs) | (r_edest == bus.id_rt));
  assign w_bubble  = bus.flush | w_hz;

  // Pipeline register: bubble on flush or hazard, else capture the decoded instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ewreg   <= 1'b0;
      r_em2reg  <= 1'b0;
      r_ewmem   <= 1'b0;
      r_ealuimm <= 1'b0;
      r_ealuc   <= 4'b0000;
      r_edest   <= RW'(0);
      r_ea      <= DW'(0);
      r_eb      <= DW'(0);
      r_eimm    <= DW'(0);
    end else if (w_bubble) begin
      r_ewreg   <= 1'b0;
      r_em2reg  <= 1'b0;
      r_ewmem   <= 1'b0;
      r_ealuimm <= 1'b0;
      r_ealuc   <= 4'b0000;
      r_edest   <= RW'(0);
      r_ea      <= DW'(0);
      r_eb      <= DW'(0);
      r_eimm    <= DW'(0);
    end else begin
      r_ewreg   <= bus.id_wreg;
      r_em2reg  <= bus.id_m2reg;
      r_ewmem   <= bus.id_wmem;
      r_ealuimm <= bus.id_aluimm;
      r_ealuc   <= bus.id_aluc;
      r_edest   <= w_dest;
      r_ea      <= w_fwd_a;
      r_eb      <= w_fwd_b;
      r_eimm    <= w_imm_ext;
    end
  end

  assign bus.ewreg    = r_ewreg;
  assign bus.em2reg   = r_em2reg;
  assign bus.ewmem    = r_ewmem;
  assign bus.ealuimm  = r_ealuimm;
  assign bus.ealuc    = r_ealuc;
  assign bus.edestReg = r_edest;
  assign bus.ea       = r_ea;
  assign bus.eb       = r_eb;
  assign bus.eimm     = r_eimm;
  assign bus.wpcir    = ~w_hz;

`ifdef IDEX_PERF_CNT_EN
  logic [CNTW-1:0] r_bubble_cnt;

  // Saturating count of every bubble loaded (hazard or flush).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bubble_cnt <= CNTW'(0);
    end else if (w_bubble && (r_bubble_cnt != {CNTW{1'b1}})) begin
      r_bubble_cnt <= r_bubble_cnt + CNTW'(1);
    end else begin
      r_bubble_cnt <= r_bubble_cnt;
    end
  end

  assign bus.bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed table-driven bench for id_ex_stage_reg plus hand sequences for reset and counter corners.
module tb_id_ex_stage_reg;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  id_ex_stage_reg_if #(.DW(32), .RW(5), .CNTW(16)) bus ();

  id_ex_stage_reg #(.DW(32), .RW(5), .CNTW(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush, wreg, m2reg, wmem, aluimm, regrt, mm2reg;
    logic [3:0]  aluc;
    logic [1:0]  fwda, fwdb;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] qa, qb, exres, memres, memdout;
    logic        x_wpcir, x_ewreg, x_em2reg, x_ewmem, x_ealuimm;
    logic [3:0]  x_ealuc;
    logic [4:0]  x_dest;
    logic [31:0] x_ea, x_eb, x_eimm;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.flush       = v.flush;
    bus.id_wreg     = v.wreg;
    bus.id_m2reg    = v.m2reg;
    bus.id_wmem     = v.wmem;
    bus.id_aluimm   = v.aluimm;
    bus.id_regrt    = v.regrt;
    bus.mm2reg      = v.mm2reg;
    bus.id_aluc     = v.aluc;
    bus.id_fwda     = v.fwda;
    bus.id_fwdb     = v.fwdb;
    bus.id_rs       = v.rs;
    bus.id_rt       = v.rt;
    bus.id_rd       = v.rd;
    bus.id_imm      = v.imm;
    bus.id_qa       = v.qa;
    bus.id_qb       = v.qb;
    bus.ex_alu_res  = v.exres;
    bus.mem_alu_res = v.memres;
    bus.mem_dout    = v.memdout;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " ewreg"},   32'(bus.ewreg),    32'h0);
    chk({tag, " em2reg"},  32'(bus.em2reg),   32'h0);
    chk({tag, " edest"},   32'(bus.edestReg), 32'h0);
    chk({tag, " ea"},      bus.ea,            32'h0);
    chk({tag, " eimm"},    bus.eimm,          32'h0);
    chk({tag, " wpcir"},   32'(bus.wpcir),    32'h1);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    // fl wr m2 wm ai rt mm  aluc  fa fb  rs rt rd  imm  qa qb ex mr md | wpcir ewreg em2 ewm eai aluc dest ea eb eimm
    vt[0]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 4'h2, 2'd0,2'd0, 5'd1,5'd2,5'd3, 16'h1820,
               32'h5, 32'h7, 32'h0, 32'h0, 32'h0,
               1'b1,1'b1,1'b0,1'b0,1'b0, 4'h2, 5'd3, 32'h5, 32'h7, 32'h0000_1820};
    vt[1]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 4'h2, 2'd1,2'd2, 5'd5,5'd6,5'd7, 16'h3820,
               32'h99, 32'h88, 32'h11, 32'h55, 32'hAB,
               1'b1,1'b1,1'b0,1'b0,1'b0, 4'h2, 5'd7, 32'h11, 32'hAB, 32'h0000_3820};
    vt[2]  = '{1'b0,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0, 4'h2, 2'd3,2'd2, 5'd8,5'd9,5'd10, 16'h8001,
               32'h1234, 32'h4444, 32'h11, 32'h55, 32'hAB,
               1'b1,1'b1,1'b0,1'b0,1'b1, 4'h2, 5'd9, 32'h1234, 32'h55, 32'hFFFF_8001};
    vt[3]  = '{1'b0,1'b1,1'b1,1'b0,1'b1,1'b1,1'b0, 4'h2, 2'd0,2'd0, 5'd2,5'd4,5'd0, 16'h7FFF,
               32'h100, 32'h200, 32'h0, 32'h0, 32'h0,
               1'b1,1'b1,1'b1,1'b0,1'b1, 4'h2, 5'd4, 32'h100, 32'h200, 32'h0000_7FFF};
    vt[4]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 4'h2, 2'd0,2'd0, 5'd4,5'd1,5'd5, 16'h2800,
               32'h300, 32'h400, 32'h0, 32'h0, 32'h0,
               1'b0,1'b0,1'b0,1'b0,1'b0, 4'h0, 5'd0, 32'h0, 32'h0, 32'h0};
    vt[5]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 4'h2, 2'd2,2'd0, 5'd4,5'd1,5'd5, 16'h2800,
               32'h300, 32'h400, 32'h0, 32'h104, 32'hDEAD,
               1'b1,1'b1,1'b0,1'b0,1'b0, 4'h2, 5'd5, 32'hDEAD, 32'h400, 32'h0000_2800};
    vt[6]  = '{1'b0,1'b1,1'b1,1'b0,1'b1,1'b1,1'b0, 4'h2, 2'd0,2'd0, 5'd3,5'd0,5'd0, 16'h0010,
               32'h500, 32'h600, 32'h0, 32'h0, 32'h0,
               1'b1,1'b1,1'b1,1'b0,1'b1, 4'h2, 5'd0, 32'h500, 32'h600, 32'h0000_0010};
    vt[7]  = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 4'h2, 2'd0,2'd0, 5'd0,5'd0,5'd8, 16'h4000,
               32'h700, 32'h800, 32'h0, 32'h0, 32'h0,
               1'b1,1'b1,1'b0,1'b0,1'b0, 4'h2, 5'd8, 32'h700, 32'h800, 32'h0000_4000};
    vt[8]  = '{1'b0,1'b1,1'b1,1'b0,1'b1,1'b1,1'b0, 4'h2, 2'd0,2'd0, 5'd3,5'd6,5'd0, 16'h0004,
               32'h900, 32'hA00, 32'h0, 32'h0, 32'h0,
               1'b1,1'b1,1'b1,1'b0,1'b1, 4'h2, 5'd6, 32'h900, 32'hA00, 32'h0000_0004};
    vt[9]  = '{1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 4'h2, 2'd0,2'd0, 5'd1,5'd6,5'd9, 16'h3000,
               32'hB00, 32'hC00, 32'h0, 32'h0, 32'h0,
               1'b0,1'b0,1'b0,1'b0,1'b0, 4'h0, 5'd0, 32'h0, 32'h0, 32'h0};
    vt[10] = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,1'b0, 4'h7, 2'd0,2'd0, 5'd6,5'd6,5'd6, 16'h1234,
               32'hD00, 32'hE00, 32'h0, 32'h0, 32'h0,
               1'b1,1'b0,1'b0,1'b0,1'b0, 4'h0, 5'd0, 32'h0, 32'h0, 32'h0};
    vt[11] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,1'b0, 4'h2, 2'd0,2'd1, 5'd1,5'd2,5'd0, 16'hFFFC,
               32'h40, 32'h77, 32'h3C, 32'h0, 32'h0,
               1'b1,1'b0,1'b0,1'b1,1'b1, 4'h2, 5'd2, 32'h40, 32'h3C, 32'hFFFF_FFFC};

    rst_n = 1'b0;
    drive(vt[0]);
    #3;
    chk_zero("reset");
`ifdef IDEX_PERF_CNT_EN
    chk("reset bubble_cnt", 32'(bus.bubble_cnt), 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      drive(vt[i]);
      #1;
      chk($sformatf("v%0d wpcir", i), 32'(bus.wpcir), 32'(vt[i].x_wpcir));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d ewreg", i),   32'(bus.ewreg),    32'(vt[i].x_ewreg));
      chk($sformatf("v%0d em2reg", i),  32'(bus.em2reg),   32'(vt[i].x_em2reg));
      chk($sformatf("v%0d ewmem", i),   32'(bus.ewmem),    32'(vt[i].x_ewmem));
      chk($sformatf("v%0d ealuimm", i), 32'(bus.ealuimm),  32'(vt[i].x_ealuimm));
      chk($sformatf("v%0d ealuc", i),   32'(bus.ealuc),    32'(vt[i].x_ealuc));
      chk($sformatf("v%0d edest", i),   32'(bus.edestReg), 32'(vt[i].x_dest));
      chk($sformatf("v%0d ea", i),      bus.ea,            vt[i].x_ea);
      chk($sformatf("v%0d eb", i),      bus.eb,            vt[i].x_eb);
      chk($sformatf("v%0d eimm", i),    bus.eimm,          vt[i].x_eimm);
    end
`ifdef IDEX_PERF_CNT_EN
    chk("bubble_cnt after table", 32'(bus.bubble_cnt), 32'h3);
`endif

    // Reset asserted mid-stall: wpcir must return high without waiting for a clock edge.
    @(negedge clk);
    drive(vt[3]);
    @(posedge clk);
    @(negedge clk);
    drive(vt[4]);
    #1;
    chk("midstall wpcir low", 32'(bus.wpcir), 32'h0);
    #1;
    rst_n = 1'b0;
    #1;
    chk_zero("midstall reset");
`ifdef IDEX_PERF_CNT_EN
    chk("midstall bubble_cnt", 32'(bus.bubble_cnt), 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

`ifdef IDEX_PERF_CNT_EN
    // Hold flush long enough to exceed the counter range and confirm it saturates.
    drive(vt[10]);
    repeat (65540) @(posedge clk);
    #1;
    chk("bubble_cnt saturate", 32'(bus.bubble_cnt), 32'h0000_FFFF);
    @(negedge clk);
    drive(vt[11]);
    @(posedge clk);
    #1;
    chk("bubble_cnt hold at max", 32'(bus.bubble_cnt), 32'h0000_FFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
